gl_matrix_stack_ctrl: RTL and testbench

- Sequences the modelview and projection matrix stacks held in a shared simple-dual-port BRAM.
- Executes push, pop and load-identity requests from gl_decode as word-serial copy/fill operations.
- Tracks per-stack pointers and publishes the base address of each current top matrix to the matrix multiply datapath.
- Asserts busy while sequencing so gl_decode stalls.

---
 rtl/gl_matrix_stack_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_gl_matrix_stack_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gl_matrix_stack_ctrl.sv
// rtl/gl_matrix_stack_ctrl.sv - modelview/projection matrix stack sequencer over a shared BRAM
// Optional scrub-on-pop (zero the popped slot) is enabled by defining GL_MSTACK_SCRUB_ON_POP_EN.
module gl_matrix_stack_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int MV_BASE    = 0,
  parameter int PROJ_BASE  = 512,
  parameter int MV_DEPTH   = 32,
  parameter int PROJ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic              pop_en,
  input  logic              load_id_en,
  input  logic              matrix_mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mv_top_addr,
  output logic [ADDR_W-1:0] proj_top_addr,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COPY  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_ONE   = 3'd3;
  localparam logic [2:0] S_SCRUB = 3'd4;

  localparam logic [4:0] MV_LAST   = 5'(MV_DEPTH - 1);
  localparam logic [4:0] PROJ_LAST = 5'(PROJ_DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        mv_sp_q, mv_sp_d;
  logic [4:0]        proj_sp_q, proj_sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [4:0]        sel_sp;
  logic [4:0]        sel_last;
  logic [ADDR_W-1:0] sel_base;
  logic              sp_inc, sp_dec, sp_mode;

  assign mv_top_addr   = ADDR_W'(MV_BASE) + ADDR_W'({mv_sp_q, 4'b0000});
  assign proj_top_addr = ADDR_W'(PROJ_BASE) + ADDR_W'({proj_sp_q, 4'b0000});
  assign sel_sp        = matrix_mode ? mv_sp_q : proj_sp_q;
  assign sel_last      = matrix_mode ? MV_LAST : PROJ_LAST;
  assign sel_base      = matrix_mode ? mv_top_addr : proj_top_addr;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  // All slot addressing uses base_q latched at accept, so sp may move
  // one cycle early to line the top-address update up with done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    base_d    = base_q;
    mv_sp_d   = mv_sp_q;
    proj_sp_d = proj_sp_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    sp_mode   = mode_q;
    case (state_q)
      S_IDLE: begin
        sp_mode = matrix_mode;
        if (push_en || pop_en || load_id_en) begin
          mode_d = matrix_mode;
          base_d = sel_base;
          cnt_d  = 5'd0;
        end
        if (push_en) begin
          if (sel_sp == sel_last) begin
            ovf_d   = 1'b1;
            state_d = S_ONE;
          end else begin
            state_d = S_COPY;
          end
        end else if (pop_en) begin
          if (sel_sp == 5'd0) begin
            udf_d   = 1'b1;
            state_d = S_ONE;
          end else begin
`ifdef GL_MSTACK_SCRUB_ON_POP_EN
            state_d = S_SCRUB;
`else
            sp_dec  = 1'b1;
            state_d = S_ONE;
`endif
          end
        end else if (load_id_en) begin
          state_d = S_FILL;
        end
      end
      S_COPY: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) sp_inc = 1'b1;
        if (cnt_q == 5'd16) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end
      end
      S_SCRUB: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd14) sp_dec = 1'b1;
        if (cnt_q == 5'd15) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (sp_inc) begin
      if (sp_mode) mv_sp_d = mv_sp_q + 5'd1;
      else         proj_sp_d = proj_sp_q + 5'd1;
    end
    if (sp_dec) begin
      if (sp_mode) mv_sp_d = mv_sp_q - 5'd1;
      else         proj_sp_d = proj_sp_q - 5'd1;
    end
  end

  // Copy is a one-deep read/write pipeline: word c-1 is written while word c is read.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 32'h0;
    case (state_q)
      S_COPY: begin
        if (cnt_q != 5'd16) rd_addr = base_q + ADDR_W'(cnt_q);
        if (cnt_q != 5'd0) begin
          wr_en   = 1'b1;
          wr_addr = base_q + ADDR_W'(cnt_q) + ADDR_W'(15);
          wr_data = rd_data;
        end
        done = (cnt_q == 5'd16);
      end
      S_FILL: begin
        wr_en   = 1'b1;
        wr_addr = base_q + ADDR_W'(cnt_q);
        wr_data = (cnt_q[1:0] == cnt_q[3:2]) ? 32'h3F80_0000 : 32'h0;
        done    = (cnt_q == 5'd15);
      end
      S_SCRUB: begin
        wr_en   = 1'b1;
        wr_addr = base_q + ADDR_W'(cnt_q);
        done    = (cnt_q == 5'd15);
      end
      S_ONE:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      mode_q    <= 1'b0;
      base_q    <= '0;
      mv_sp_q   <= 5'd0;
      proj_sp_q <= 5'd0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      mv_sp_q   <= mv_sp_d;
      proj_sp_q <= proj_sp_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

endmodule

// File: tb/tb_gl_matrix_stack_ctrl.sv
// tb/tb_gl_matrix_stack_ctrl.sv - table-driven bench for gl_matrix_stack_ctrl with a BRAM model
module tb_gl_matrix_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst, push_en, pop_en, load_id_en, matrix_mode;
  logic        busy, done, overflow, underflow, wr_en;
  logic [9:0]  mv_top_addr, proj_top_addr, rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic        prefill;
  logic [31:0] mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef GL_MSTACK_SCRUB_ON_POP_EN
  localparam int POP_BUSY = 16;
  localparam int POP_WR   = 16;
`else
  localparam int POP_BUSY = 1;
  localparam int POP_WR   = 0;
`endif

  gl_matrix_stack_ctrl dut (
    .clk(clk), .rst(rst), .push_en(push_en), .pop_en(pop_en), .load_id_en(load_id_en),
    .matrix_mode(matrix_mode), .busy(busy), .done(done), .mv_top_addr(mv_top_addr),
    .proj_top_addr(proj_top_addr), .overflow(overflow), .underflow(underflow),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       push, pop, ld, mode;
    int         exp_busy, exp_wr;
    logic [9:0] exp_mv, exp_proj;
    logic       exp_ovf, exp_udf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind 0: identity matrix, 1: untouched prefill pattern of src, 2: all zero
  task automatic check_region(input string name, input int base, input int kind, input int src);
    int bad = 0;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      if (kind == 0)      e = (i % 5 == 0) ? 32'h3F80_0000 : 32'h0;
      else if (kind == 1) e = 32'hA500_0000 | 32'(src + i);
      else                e = 32'h0;
      if (mem[base + i] !== e) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic run_op(input logic p, input logic q, input logic l, input logic m,
                        input int inject, output int nb, output int nw, output logic got);
    int k = 0;
    @(negedge clk);
    check("idle_before_op", {30'd0, busy, done}, 32'd0);
    push_en = p; pop_en = q; load_id_en = l; matrix_mode = m;
    @(negedge clk);
    push_en = 1'b0; pop_en = 1'b0; load_id_en = 1'b0;
    nb = 0; nw = 0; got = 1'b0;
    while (!got && k < 40) begin
      if (busy)  nb++;
      if (wr_en) nw++;
      if (done) got = 1'b1;
      else begin
        pop_en = (k == inject);
        @(negedge clk);
      end
      k++;
    end
    pop_en = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
  endtask

  int   nb, nw;
  logic got;

  initial begin
    rst = 1'b1; prefill = 1'b1;
    push_en = 1'b0; pop_en = 1'b0; load_id_en = 1'b0; matrix_mode = 1'b0;
    repeat (2) @(negedge clk);
    prefill = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_mv_top", 32'(mv_top_addr), 32'd0);
    check("rst_proj_top", 32'(proj_top_addr), 32'd512);
    check("rst_flags", {28'd0, busy, done, overflow, underflow}, 32'd0);
    check("rst_bram_if", {11'd0, wr_en, rd_addr, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);

    //         push  pop   ld    mode  busy      wr      mv      proj    ovf   udf
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 16,       16,     10'd0,  10'd512, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 17,       16,     10'd16, 10'd512, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,        0,      10'd16, 10'd512, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 17,       16,     10'd16, 10'd528, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 17,       16,     10'd16, 10'd544, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 17,       16,     10'd16, 10'd560, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,        0,      10'd16, 10'd560, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, POP_BUSY, POP_WR, 10'd16, 10'd544, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, POP_BUSY, POP_WR, 10'd0,  10'd544, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 16,       16,     10'd0,  10'd544, 1'b1, 1'b1};

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].push, vecs[v].pop, vecs[v].ld, vecs[v].mode, -1, nb, nw, got);
      check($sformatf("v%0d_busy_cycles", v), 32'(nb), 32'(vecs[v].exp_busy));
      check($sformatf("v%0d_wr_cycles", v), 32'(nw), 32'(vecs[v].exp_wr));
      check($sformatf("v%0d_mv_top", v), 32'(mv_top_addr), 32'(vecs[v].exp_mv));
      check($sformatf("v%0d_proj_top", v), 32'(proj_top_addr), 32'(vecs[v].exp_proj));
      check($sformatf("v%0d_flags", v), {30'd0, overflow, underflow},
            {30'd0, vecs[v].exp_ovf, vecs[v].exp_udf});
      @(negedge clk);
      case (v)
        0: check_region("mem_ident_0", 0, 0, 0);
        1: check_region("mem_copy_16", 16, 0, 0);
        3: check_region("mem_copy_528", 528, 1, 512);
        5: check_region("mem_copy_560", 560, 1, 512);
`ifdef GL_MSTACK_SCRUB_ON_POP_EN
        7: check_region("mem_scrub_560", 560, 2, 0);
`else
        7: check_region("mem_nopop_560", 560, 1, 512);
`endif
        9: check_region("mem_ident_544", 544, 0, 0);
        default: ;
      endcase
    end

    // all three requests at once, then a pop pulse mid-push that must be dropped
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 5, nb, nw, got);
    check("multi_busy_cycles", 32'(nb), 32'd17);
    check("multi_wr_cycles", 32'(nw), 32'd16);
    repeat (3) @(negedge clk);
    check("multi_mv_top", 32'(mv_top_addr), 32'd16);
    check("multi_proj_top", 32'(proj_top_addr), 32'd544);
    check("multi_idle", {31'd0, busy}, 32'd0);
    check_region("multi_no_fill_0", 0, 0, 0);

    // reset while the push copy is at c=8
    push_en = 1'b1; matrix_mode = 1'b1;
    @(negedge clk);
    push_en = 1'b0;
    repeat (8) @(negedge clk);
    check("midpush_wr_active", {31'd0, wr_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mv_top", 32'(mv_top_addr), 32'd0);
    check("midrst_proj_top", 32'(proj_top_addr), 32'd512);
    check("midrst_flags", {30'd0, overflow, underflow}, 32'd0);

    run_op(1'b1, 1'b0, 1'b0, 1'b1, -1, nb, nw, got);
    check("repush_mv_top", 32'(mv_top_addr), 32'd16);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, -1, nb, nw, got);
    check("repop_busy_cycles", 32'(nb), 32'(POP_BUSY));
    check("repop_wr_cycles", 32'(nw), 32'(POP_WR));
    check("repop_mv_top", 32'(mv_top_addr), 32'd0);
    @(negedge clk);
`ifdef GL_MSTACK_SCRUB_ON_POP_EN
    check_region("repop_scrub_16", 16, 2, 0);
`else
    check_region("repop_keep_16", 16, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
